pdf_header_checker: RTL

- Consumes the byte stream produced by the file reader stage, one ASCII byte per accepted beat.
- Skips a bounded run of leading whitespace, then matches the literal "%PDF-1." and captures the single minor-version digit.
- Produces a sticky pass/fail verdict with the decoded version, for the downstream classification logic.
- Stops accepting bytes after a verdict until `clear` or reset.

---
 rtl/pdf_pkg.sv | 51 +++++
 rtl/ascii_class.sv | 18 +
 rtl/pdf_header_checker.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pdf_pkg.sv
// Shared constants for the PDF header checker: FSM states, header pattern,
// whitespace bytes and error codes.
package pdf_pkg;

  typedef enum logic [2:0] {
    SEEK    = 3'd0,
    MATCH   = 3'd1,
    VERSION = 3'd2,
    PASS    = 3'd3,
    FAIL    = 3'd4
  } state_t;

  localparam logic [7:0] CH_PCT  = 8'h25;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_D    = 8'h44;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_DOT  = 8'h2E;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  localparam logic [7:0] WS_SP = 8'h20;
  localparam logic [7:0] WS_HT = 8'h09;
  localparam logic [7:0] WS_LF = 8'h0A;
  localparam logic [7:0] WS_CR = 8'h0D;

  localparam logic [2:0] PAT_LAST = 3'd6;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_WS   = 2'd1;
  localparam logic [1:0] ERR_PAT  = 2'd2;
  localparam logic [1:0] ERR_VER  = 2'd3;

  // Byte of "%PDF-1." at the given index.
  function automatic logic [7:0] pat_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CH_PCT;
      3'd1:    b = CH_P;
      3'd2:    b = CH_D;
      3'd3:    b = CH_F;
      3'd4:    b = CH_DASH;
      3'd5:    b = CH_1;
      3'd6:    b = CH_DOT;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ascii_class.sv
// Combinational ASCII byte classifier: whitespace, decimal digit and digit value.
module ascii_class
  import pdf_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_ws,
  output logic       is_digit,
  output logic [3:0] digit_val
);

  always_comb begin
    is_ws     = (ch == WS_SP) || (ch == WS_HT) || (ch == WS_LF) || (ch == WS_CR);
    is_digit  = (ch >= CH_0) && (ch <= CH_9);
    // '0'..'9' are 0x30..0x39, so the low nibble is the value
    digit_val = ch[3:0];
  end

endmodule

// File: rtl/pdf_header_checker.sv
// Skips bounded leading whitespace, matches "%PDF-1." and captures the minor
// version digit into a sticky verdict. Optional err_code output: PDF_ERR_CODE_EN.
module pdf_header_checker
  import pdf_pkg::*;
#(
  parameter int unsigned MAX_SKIP = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             done,
  output logic             is_pdf,
  output logic [3:0]       version,
  output logic [CNT_W-1:0] byte_count
`ifdef PDF_ERR_CODE_EN
  ,
  output logic [1:0]       err_code
`endif
);

  state_t           state_q, state_n;
  logic [3:0]       skip_q, skip_n;
  logic [2:0]       idx_q, idx_n;
  logic [3:0]       ver_n;
  logic             done_n, is_pdf_n, ready_n;
  logic [CNT_W-1:0] cnt_n;
  logic             accept, go_fail;
  logic             is_ws, is_digit;
  logic [3:0]       digit_val;
`ifdef PDF_ERR_CODE_EN
  logic [1:0]       err_n, fail_code;
`endif

  ascii_class u_class (
    .ch        (in_byte),
    .is_ws     (is_ws),
    .is_digit  (is_digit),
    .digit_val (digit_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEEK;
      skip_q     <= 4'd0;
      idx_q      <= 3'd0;
      version    <= 4'd0;
      done       <= 1'b0;
      is_pdf     <= 1'b0;
      in_ready   <= 1'b1;
      byte_count <= '0;
`ifdef PDF_ERR_CODE_EN
      err_code   <= ERR_NONE;
`endif
    end else begin
      state_q    <= state_n;
      skip_q     <= skip_n;
      idx_q      <= idx_n;
      version    <= ver_n;
      done       <= done_n;
      is_pdf     <= is_pdf_n;
      in_ready   <= ready_n;
      byte_count <= cnt_n;
`ifdef PDF_ERR_CODE_EN
      err_code   <= err_n;
`endif
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_n  = state_q;
    skip_n   = skip_q;
    idx_n    = idx_q;
    ver_n    = version;
    done_n   = done;
    is_pdf_n = is_pdf;
    cnt_n    = byte_count;
    go_fail  = 1'b0;
    accept   = in_valid && in_ready;
`ifdef PDF_ERR_CODE_EN
    err_n     = err_code;
    fail_code = ERR_NONE;
`endif

    if (clear) begin
      state_n  = SEEK;
      skip_n   = 4'd0;
      idx_n    = 3'd0;
      ver_n    = 4'd0;
      done_n   = 1'b0;
      is_pdf_n = 1'b0;
      cnt_n    = '0;
`ifdef PDF_ERR_CODE_EN
      err_n    = ERR_NONE;
`endif
    end else if (accept) begin
      if (byte_count != {CNT_W{1'b1}}) cnt_n = byte_count + CNT_W'(1);
      case (state_q)
        SEEK: begin
          if (is_ws) begin
            skip_n = skip_q + 4'd1;
            // 5-bit compare so MAX_SKIP=15 cannot wrap
            if (({1'b0, skip_q} + 5'd1) > 5'(MAX_SKIP)) begin
              go_fail = 1'b1;
`ifdef PDF_ERR_CODE_EN
              fail_code = ERR_WS;
`endif
            end
          end else if (in_byte == CH_PCT) begin
            state_n = MATCH;
            idx_n   = 3'd1;
          end else begin
            go_fail = 1'b1;
`ifdef PDF_ERR_CODE_EN
            fail_code = ERR_PAT;
`endif
          end
        end
        MATCH: begin
          if (in_byte == pat_byte(idx_q)) begin
            if (idx_q == PAT_LAST) state_n = VERSION;
            else idx_n = idx_q + 3'd1;
          end else begin
            go_fail = 1'b1;
`ifdef PDF_ERR_CODE_EN
            fail_code = ERR_PAT;
`endif
          end
        end
        VERSION: begin
          if (is_digit) begin
            state_n  = PASS;
            ver_n    = digit_val;
            done_n   = 1'b1;
            is_pdf_n = 1'b1;
          end else begin
            go_fail = 1'b1;
`ifdef PDF_ERR_CODE_EN
            fail_code = ERR_VER;
`endif
          end
        end
        default: ;
      endcase

      if (go_fail) begin
        state_n  = FAIL;
        done_n   = 1'b1;
        is_pdf_n = 1'b0;
        ver_n    = 4'd0;
`ifdef PDF_ERR_CODE_EN
        err_n    = fail_code;
`endif
      end
    end

    ready_n = ~done_n;
  end

endmodule
